// File: rtl/tdm_demux.sv
// tdm_demux -- time-division demultiplexer.
// A shared word line carries N_CH slots per frame; frame_sync marks the
// slot-0 word. Each accepted word is registered into its channel field of
// ch_data with a one-cycle ch_valid strobe. frame_done pulses with the last
// slot; frame_err pulses when a sync arrives mid-frame (the frame restarts).
// Optional feature macro: TDM_DEMUX_PARITY_EN adds din_par (even parity over
// din) and par_err. A word that fails parity is dropped, but the slot counter
// still advances so the frame stays aligned.
//
// Handshake: a word is accepted on any rising edge where din_valid=1; there
// is no back-pressure, so din and frame_sync are only meaningful then.
// The FSM state is visible on busy (busy=1 exactly when the state is RECV).
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
`ifdef TDM_DEMUX_PARITY_EN
  ,
  input  logic              din_par,
  output logic              par_err
`endif
);

  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RECV = 1'b1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(N_CH - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

  logic              r_state;
  logic [SW-1:0]     r_slot;
  logic [N_CH*W-1:0] r_ch_data;
  logic [N_CH-1:0]   r_ch_valid;
  logic              r_frame_done;
  logic              r_frame_err;

  logic              w_next_state;
  logic [SW-1:0]     w_next_slot;
  logic              w_hit;      // accepted word lands in a slot
  logic [SW-1:0]     w_idx;      // slot the word lands in
  logic              w_done;
  logic              w_err;
  logic              w_par_ok;
  logic              w_wr;

`ifdef TDM_DEMUX_PARITY_EN
  logic              r_par_err;
  assign w_par_ok = ((^din) == din_par);
`else
  assign w_par_ok = 1'b1;
`endif

  // A parity-failed word consumes its slot but never reaches the channel.
  assign w_wr = w_hit & w_par_ok;

  // Next-state decode: where the accepted word goes and how the frame advances.
  always_comb begin
    w_next_state = r_state;
    w_next_slot  = r_slot;
    w_hit        = 1'b0;
    w_idx        = '0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    if (din_valid) begin
      if (frame_sync) begin
        // Sync always starts a frame; seen while receiving it is an error.
        w_hit = 1'b1;
        w_idx = '0;
        w_err = (r_state == ST_RECV);
        if (N_CH == 1) begin
          w_done       = 1'b1;
          w_next_slot  = '0;
          w_next_state = ST_IDLE;
        end else begin
          w_next_slot  = SLOT_ONE;
          w_next_state = ST_RECV;
        end
      end else if (r_state == ST_RECV) begin
        w_hit = 1'b1;
        w_idx = r_slot;
        if (r_slot == SLOT_LAST) begin
          w_done       = 1'b1;
          w_next_slot  = '0;
          w_next_state = ST_IDLE;
        end else begin
          w_next_slot = r_slot + SLOT_ONE;
        end
      end
      // Unsynced words while IDLE are silently dropped.
    end
  end

  // State, slot counter, channel registers and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_slot       <= '0;
      r_ch_data    <= '0;
      r_ch_valid   <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_par_err    <= 1'b0;
`endif
    end else begin
      r_state      <= w_next_state;
      r_slot       <= w_next_slot;
      r_frame_done <= w_done;
      r_frame_err  <= w_err;
`ifdef TDM_DEMUX_PARITY_EN
      r_par_err    <= w_hit & ~w_par_ok;
`endif
      for (int k = 0; k < N_CH; k++) begin
        if (w_wr && (w_idx == SW'(k))) begin
          r_ch_data[k*W +: W] <= din;
          r_ch_valid[k]       <= 1'b1;
        end else begin
          r_ch_valid[k]       <= 1'b0;
        end
      end
    end
  end

  assign ch_data    = r_ch_data;
  assign ch_valid   = r_ch_valid;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state == ST_RECV);
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err    = r_par_err;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux -- directed bench for tdm_demux with N_CH=4, W=8.
// Drivers apply inputs between edges and sample outputs 1 time unit after
// the accepting edge. A negedge monitor pops completed-frame images from
// exp_q whenever frame_done is seen.
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;

  logic              clk;
  logic              rst;
  logic [W-1:0]      din;
  logic              din_valid;
  logic              frame_sync;
  logic [N_CH*W-1:0] ch_data;
  logic [N_CH-1:0]   ch_valid;
  logic              frame_done;
  logic              frame_err;
  logic              busy;
`ifdef TDM_DEMUX_PARITY_EN
  logic              din_par;
  logic              par_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic par_flip = 1'b0;
  logic mon_en   = 1'b0;
  logic [N_CH*W-1:0] exp_q[$];

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .din_par    (din_par),
    .par_err    (par_err)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver: one accepted word, then check the strobes it produced.
  task automatic send_word(input string tag, input logic [7:0] d, input logic s,
                           input logic [3:0] ev, input logic ed, input logic ee,
                           input logic eb);
    din        = d;
    frame_sync = s;
    din_valid  = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
    din_par    = (^d) ^ par_flip;
`endif
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    check_eq({tag, "_valid"}, 64'(ch_valid), 64'(ev));
    check_eq({tag, "_done"}, 64'(frame_done), 64'(ed));
    check_eq({tag, "_err"}, 64'(frame_err), 64'(ee));
    check_eq({tag, "_busy"}, 64'(busy), 64'(eb));
`ifdef TDM_DEMUX_PARITY_EN
    check_eq({tag, "_perr"}, 64'(par_err), 64'(par_flip));
`endif
  endtask

  // Driver: idle cycles with junk on din/frame_sync, which must be ignored.
  task automatic idle_cycles(input string tag, input int n, input logic eb);
    for (int i = 0; i < n; i++) begin
      din_valid  = 1'b0;
      frame_sync = 1'b1;
      din        = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check_eq({tag, "_gap_valid"}, 64'(ch_valid), 64'd0);
      check_eq({tag, "_gap_done"}, 64'(frame_done), 64'd0);
      check_eq({tag, "_gap_busy"}, 64'(busy), 64'(eb));
    end
    frame_sync = 1'b0;
  endtask

  // Driver: a clean 4-slot frame (first byte in w[7:0]) with gap cycles between words.
  task automatic send_frame(input string tag, input logic [31:0] w, input int gap);
    logic [31:0] v;
    v = w;
    exp_q.push_back(w);
    for (int i = 0; i < N_CH; i++) begin
      send_word(tag, v[i*8 +: 8], (i == 0), 4'(1 << i), (i == N_CH - 1), 1'b0, (i != N_CH - 1));
      if (gap > 0) idle_cycles(tag, gap, (i != N_CH - 1));
    end
    check_eq({tag, "_data"}, 64'(ch_data), 64'(w));
  endtask

  // Scoreboard: each frame_done must match the next expected frame image.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("valid_onehot0", 64'($onehot0(ch_valid)), 64'd1);
      if (frame_done === 1'b1) begin
        if (exp_q.size() == 0) check_eq("done_unexpected", 64'd1, 64'd0);
        else check_eq("done_frame_data", 64'(ch_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    din_par    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_data", 64'(ch_data), 64'd0);
    check_eq("rst_valid", 64'(ch_valid), 64'd0);
    check_eq("rst_done", 64'(frame_done), 64'd0);
    check_eq("rst_err", 64'(frame_err), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    mon_en = 1'b1;

    // Unsynced words while IDLE are dropped.
    send_word("idle55", 8'h55, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    send_word("idle66", 8'h66, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check_eq("idle_data", 64'(ch_data), 64'd0);

    // Back-to-back frame.
    send_frame("b2b", 32'h44332211, 0);
    idle_cycles("b2b_after", 1, 1'b0);

    // Same frame with 3-cycle gaps.
    send_frame("gap", 32'h44332211, 3);

    // Mid-frame sync: error, restart.
    exp_q.push_back(32'hFFEEDDCC);
    send_word("rs_aa", 8'hAA, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
    send_word("rs_bb", 8'hBB, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
    send_word("rs_cc", 8'hCC, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1);
    send_word("rs_dd", 8'hDD, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
    send_word("rs_ee", 8'hEE, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1);
    send_word("rs_ff", 8'hFF, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
    check_eq("rs_data", 64'(ch_data), 64'hFFEEDDCC);

    // Sync on the final slot is an error, not a completion.
    exp_q.push_back(32'h70605040);
    send_word("ls_10", 8'h10, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
    send_word("ls_20", 8'h20, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
    send_word("ls_30", 8'h30, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1);
    send_word("ls_40", 8'h40, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1);
    send_word("ls_50", 8'h50, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
    send_word("ls_60", 8'h60, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1);
    send_word("ls_70", 8'h70, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
    check_eq("ls_data", 64'(ch_data), 64'h70605040);

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity on slot 2: dropped, byte 2 keeps 0x60, frame still completes.
    exp_q.push_back(32'h44602211);
    send_word("pe_11", 8'h11, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
    send_word("pe_22", 8'h22, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
    par_flip = 1'b1;
    send_word("pe_33", 8'h33, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    par_flip = 1'b0;
    send_word("pe_44", 8'h44, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
    check_eq("pe_data", 64'(ch_data), 64'h44602211);
`endif

    // Reset mid-frame, with a valid word on the reset edge.
    send_word("rm_01", 8'h01, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
    send_word("rm_02", 8'h02, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
    rst       = 1'b1;
    din       = 8'h03;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    din_valid = 1'b0;
    check_eq("rm_data", 64'(ch_data), 64'd0);
    check_eq("rm_valid", 64'(ch_valid), 64'd0);
    check_eq("rm_done", 64'(frame_done), 64'd0);
    check_eq("rm_err", 64'(frame_err), 64'd0);
    check_eq("rm_busy", 64'(busy), 64'd0);
    send_frame("post_rst", 32'h04030201, 0);

    idle_cycles("tail", 2, 1'b0);
    check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
